// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetches instructions at the PC supplied by program_counter, keeps a small
//   prefetch FIFO for the decoder and advances the PC once per issued fetch.
//   Redirects flush the FIFO and cause in-flight data to be discarded.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   i_pc                  current PC from program_counter
//   o_pc_count_en         PC advance strobe, high in every issue cycle
//   i_redirect            branch/jump, held until a fetch to the target issues
//   o_mem_req/o_mem_addr  registered memory read request and address
//   i_mem_ack/i_mem_rdata read completion and instruction word
//   o_inst_valid/o_inst/o_inst_pc   FIFO head towards the decoder
//   i_inst_ready          decoder accepts the head on valid & ready
//   o_perf_cnt            decoder-starved cycle counter (IFU_PERF_CNT_EN)
//
// Build option
//   IFU_PERF_CNT_EN  adds o_perf_cnt / CNT_WIDTH: saturating count of cycles
//                    with i_inst_ready=1 and o_inst_valid=0.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module instruction_fetch_unit #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 2
`ifdef IFU_PERF_CNT_EN
  ,parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic                  o_pc_count_en,
  input  logic                  i_redirect,
  output logic                  o_mem_req,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_inst_valid,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [DATA_WIDTH-1:0] o_inst_pc,
  input  logic                  i_inst_ready
`ifdef IFU_PERF_CNT_EN
  ,output logic [CNT_WIDTH-1:0] o_perf_cnt
`endif
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALE} state_t;

  state_t                               state_q, state_d;
  logic                                 mem_req_q;
  logic [DATA_WIDTH-1:0]                mem_addr_q;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] inst_ram_q;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] pc_ram_q;
  logic [PW-1:0]                        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                        count_q;

  logic live_ack, push, pop, space, issue;

  always_comb begin
    // An ack only means something while a request is outstanding.
    live_ack = i_mem_ack && (state_q != S_IDLE);
    push     = i_mem_ack && (state_q == S_WAIT) && !i_redirect;
    pop      = (count_q != '0) && i_inst_ready && !i_redirect;
    // Pops are deliberately not credited: keeps space a short path.
    space    = (32'(count_q) + 32'(push)) < 32'(FIFO_DEPTH);
    issue    = ((state_q == S_IDLE) || live_ack) && (i_redirect || space);

    state_d = state_q;
    if (issue)
      state_d = S_WAIT;
    else if (live_ack)
      state_d = S_IDLE;
    else if (i_redirect && (state_q == S_WAIT))
      state_d = S_STALE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= i_pc;
      end else if (live_ack) begin
        mem_req_q <= 1'b0;
      end
    end
  end

  // Prefetch FIFO; the address of the completing request is the entry's PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_ram_q <= '0;
      pc_ram_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (i_redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        inst_ram_q[wr_ptr_q] <= i_mem_rdata;
        pc_ram_q[wr_ptr_q]   <= mem_addr_q;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign o_pc_count_en = issue;
  assign o_mem_req     = mem_req_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_inst_valid  = (count_q != '0);
  assign o_inst        = inst_ram_q[rd_ptr_q];
  assign o_inst_pc     = pc_ram_q[rd_ptr_q];

`ifdef IFU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] perf_q;

  // Starved-decoder counter; survives redirects, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)
      perf_q <= '0;
    else if (i_inst_ready && (count_q == '0) && (perf_q != '1))
      perf_q <= perf_q + 1'b1;
  end

  assign o_perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] i_pc;
  logic          o_pc_count_en;
  logic          i_redirect;
  logic          o_mem_req;
  logic [DW-1:0] o_mem_addr;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_rdata;
  logic          o_inst_valid;
  logic [DW-1:0] o_inst;
  logic [DW-1:0] o_inst_pc;
  logic          i_inst_ready;
`ifdef IFU_PERF_CNT_EN
  logic [15:0]   o_perf_cnt;
`endif

  instruction_fetch_unit #(.DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_pc(i_pc), .o_pc_count_en(o_pc_count_en),
    .i_redirect(i_redirect), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready)
`ifdef IFU_PERF_CNT_EN
    ,.o_perf_cnt(o_perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
  } exp_t;
  exp_t sbq[$];

  // Environment: PC model, memory model, decoder
  logic [DW-1:0] pc;
  int            lat;
  int            wcnt;
  logic          ready;
  logic          force_ack;
  logic          redir_pend;
  logic          redir_on_ack;
  logic [DW-1:0] redir_tgt;
  int            pops;
  logic [DW-1:0] last_pop_pc;
  int            perf_m;
  logic          cen_s, ack_s, req_s, valid_s, redir_s;

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    i_inst_ready = ready;
    i_redirect   = 1'b0;
    i_pc         = pc;
    i_mem_ack    = force_ack || (o_mem_req && (wcnt >= lat));
    i_mem_rdata  = force_ack ? 32'hDEAD_BEEF : 32'hA0 + o_mem_addr;
    if (redir_pend || (redir_on_ack && i_mem_ack)) begin
      redir_pend   = 1'b1;
      redir_on_ack = 1'b0;
      pc           = redir_tgt;
      i_pc         = redir_tgt;
      i_redirect   = 1'b1;
    end
    #1;
    cen_s   = o_pc_count_en;
    ack_s   = i_mem_ack;
    req_s   = o_mem_req;
    valid_s = o_inst_valid;
    redir_s = i_redirect;
    if (rst_n) begin
      if (i_redirect) begin
        sbq.delete();
      end else if (o_inst_valid && i_inst_ready) begin
        chk("sb_entry_expected", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_inst_pc", 64'(o_inst_pc), 64'(e.pc));
          chk("sb_inst", 64'(o_inst), 64'(e.inst));
        end
        last_pop_pc = o_inst_pc;
        pops++;
      end
      if (o_pc_count_en) sbq.push_back('{pc: i_pc, inst: 32'hA0 + i_pc});
      if (i_inst_ready && !o_inst_valid && perf_m < 65535) perf_m++;
    end else begin
      sbq.delete();
      perf_m = 0;
    end
    @(posedge clk);
    if (!rst_n) begin
      pc   = '0;
      wcnt = 0;
      redir_pend = 1'b0;
    end else begin
      if (cen_s) begin
        pc = pc + 1;
        if (redir_s) redir_pend = 1'b0;
      end
      if (ack_s) wcnt = 0;
      else if (req_s) wcnt++;
    end
    force_ack = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    rst_n = 1'b0; i_pc = '0; i_redirect = 1'b0; i_mem_ack = 1'b0;
    i_mem_rdata = '0; i_inst_ready = 1'b0;
    pc = '0; lat = 0; wcnt = 0; ready = 1'b0; force_ack = 1'b0;
    redir_pend = 1'b0; redir_on_ack = 1'b0; redir_tgt = '0;
    pops = 0; last_pop_pc = '0; perf_m = 0;

    // Reset state
    do_reset();
    chk("rst_mem_req", 64'(o_mem_req), 64'd0);
    chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    chk("rst_inst_valid", 64'(o_inst_valid), 64'd0);
    chk("rst_inst", 64'(o_inst), 64'd0);
    chk("rst_inst_pc", 64'(o_inst_pc), 64'd0);

    // Zero-wait memory, decoder always ready: 2-cycle issue-to-valid
    ready = 1'b1; lat = 0;
    cycle();
    chk("t1_c0_count_en", 64'(cen_s), 64'd1);
    chk("t1_c0_valid", 64'(valid_s), 64'd0);
    cycle();
    chk("t1_c1_count_en", 64'(cen_s), 64'd1);
    chk("t1_c1_valid", 64'(valid_s), 64'd0);
    cycle();
    chk("t1_c2_valid", 64'(valid_s), 64'd1);
    for (int i = 0; i < 20; i++) cycle();
    chk("t1_progress", 64'(pops >= 8), 64'd1);

    // Decoder stalled: FIFO fills with PC 0,1 and fetching stops
    do_reset();
    ready = 1'b0; lat = 0;
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_full_valid", 64'(o_inst_valid), 64'd1);
    chk("t2_full_count_en", 64'(cen_s), 64'd0);
    chk("t2_full_mem_req", 64'(o_mem_req), 64'd0);
    chk("t2_head_pc", 64'(o_inst_pc), 64'd0);
    chk("t2_head_inst", 64'(o_inst), 64'hA0);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (o_mem_req) break;
    end
    chk("t2_refetch_req", 64'(o_mem_req), 64'd1);
    chk("t2_refetch_addr", 64'(o_mem_addr), 64'd2);
    for (int i = 0; i < 6; i++) cycle();

    // Slow memory, redirect while PC 5 is outstanding
    do_reset();
    ready = 1'b1; lat = 3;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (o_mem_req && o_mem_addr == 32'd5) break;
    end
    chk("t3_reach_pc5", 64'(o_mem_addr), 64'd5);
    redir_tgt = 32'h40; redir_pend = 1'b1;
    cycle();
    chk("t3_stale_no_issue", 64'(cen_s), 64'd0);
    chk("t3_stale_addr_held", 64'(o_mem_addr), 64'd5);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (cen_s) break;
    end
    chk("t3_redirect_issue", 64'(cen_s), 64'd1);
    chk("t3_redirect_addr", 64'(o_mem_addr), 64'h40);
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (pops > p0) break;
    end
    chk("t3_first_pc", 64'(last_pop_pc), 64'h40);

    // Redirect coincident with an ack
    do_reset();
    ready = 1'b1; lat = 1;
    for (int i = 0; i < 6; i++) cycle();
    redir_tgt = 32'h80; redir_on_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (redir_s && cen_s) break;
    end
    chk("t4_ack_same_cycle", 64'(ack_s), 64'd1);
    chk("t4_issue", 64'(cen_s), 64'd1);
    chk("t4_addr", 64'(o_mem_addr), 64'h80);
    chk("t4_flushed", 64'(o_inst_valid), 64'd0);
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (pops > p0) break;
    end
    chk("t4_first_pc", 64'(last_pop_pc), 64'h80);

    // Reset while a request is outstanding; late ack must be ignored
    do_reset();
    ready = 1'b1; lat = 3;
    cycle();
    cycle();
    chk("t5_waiting", 64'(o_mem_req), 64'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t5_rst_req", 64'(o_mem_req), 64'd0);
    chk("t5_rst_valid", 64'(o_inst_valid), 64'd0);
    force_ack = 1'b1;
    cycle();
    chk("t5_restart_issue", 64'(cen_s), 64'd1);
    chk("t5_late_ack_ignored", 64'(o_inst_valid), 64'd0);
    chk("t5_restart_addr", 64'(o_mem_addr), 64'd0);
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (pops > p0) break;
    end
    chk("t5_first_pc", 64'(last_pop_pc), 64'd0);

`ifdef IFU_PERF_CNT_EN
    // Starved-decoder counter against the bench's own count
    do_reset();
    chk("t6_perf_reset", 64'(o_perf_cnt), 64'd0);
    ready = 1'b1; lat = 2;
    for (int i = 0; i < 30; i++) begin
      if (i == 15) begin
        redir_tgt = 32'h100; redir_pend = 1'b1;
      end
      cycle();
      chk("t6_perf_cnt", 64'(o_perf_cnt), 64'(perf_m));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
